dmem_arbiter: RTL and testbench

- Shares the single data-memory port of the single-cycle core between two requesters: the core load/store path and a DMA/loader port used for program/data preload and debug reads.
- Sits between the datapath's memory interface and the data memory.
- Core has default priority; DMA is guaranteed forward progress by a starvation counter.
- Tracks in-flight reads through a latency pipeline and routes read data back to the requester that issued each read.

---
 rtl/dmem_arbiter_pkg.sv | 6 +
 rtl/dmem_arbiter_rd_tag_pipe.sv | 27 ++
 rtl/dmem_arbiter.sv | 75 +++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: priority state and read owner encodings shared by the data-memory arbiter
package dmem_arbiter_pkg;
   typedef enum logic {PRI_CORE = 1'b0, PRI_DMA = 1'b1} pri_e;
   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage {valid, owner} shift register tracking reads in flight
module rd_tag_pipe
   import dmem_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_v,
   input  logic in_own,
   output logic out_v,
   output logic out_own,
   output logic busy
);
   logic [DEPTH-1:0] v, own;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v <= '0;
         own <= {DEPTH{OWN_CORE}};
      end else begin
         v <= DEPTH'({v, in_v});
         own <= DEPTH'({own, in_own});
      end
   assign out_v = v[DEPTH-1];
   assign out_own = own[DEPTH-1];
   assign busy = |v;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between core and DMA with starvation-bounded priority
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);
   localparam logic [7:0] SMAX = 8'(STARVE_MAX);
   pri_e state, state_n;
   logic [7:0] cnt, cnt_n;
   logic c_win, out_v, out_own;
   logic [DATA_W-1:0] c_q, d_q;
   always_comb begin
      c_win = c_req & (state == PRI_CORE | ~d_req);
      c_gnt = reset & c_win;
      d_gnt = reset & d_req & ~c_win;
      m_en = c_gnt | d_gnt;
      m_we = c_gnt ? c_we : d_gnt & d_we;
      m_addr = d_gnt ? d_addr : c_addr;
      m_wdata = d_gnt ? d_wdata : c_wdata;
      cnt_n = (d_req & ~d_gnt) ? ((cnt == 8'hFF) ? cnt : cnt + 8'd1) : 8'd0;
      state_n = (state == PRI_CORE) ? ((cnt_n >= SMAX) ? PRI_DMA : PRI_CORE)
                                    : ((d_gnt | ~d_req) ? PRI_CORE : PRI_DMA);
   end
   rd_tag_pipe #(.DEPTH(RD_LAT)) u_pipe (
      .clk(clk),
      .rst_n(reset),
      .in_v(m_en & ~m_we),
      .in_own(d_gnt ? OWN_DMA : OWN_CORE),
      .out_v(out_v),
      .out_own(out_own),
      .busy(busy)
   );
   assign c_rvalid = out_v & (out_own == OWN_CORE);
   assign d_rvalid = out_v & (out_own == OWN_DMA);
   assign c_rdata = c_rvalid ? m_rdata : c_q;
   assign d_rdata = d_rvalid ? m_rdata : d_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= PRI_CORE;
         cnt <= 8'd0;
         c_q <= '0;
         d_q <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         if (c_rvalid) c_q <= m_rdata;
         if (d_rvalid) d_q <= m_rdata;
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of two arbiter instances (RD_LAT 1 and 3) against a reference model
module tb_dmem_arbiter;
   localparam int N = 2;
   localparam int SM = 8;
   typedef struct {
      int due;
      bit own;
      logic [31:0] data;
   } rsp_t;
   logic clk = 1'b0;
   logic reset;
   logic c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic c_gnt [N], d_gnt [N], c_rvalid [N], d_rvalid [N], m_en [N], m_we [N], busy [N];
   logic [31:0] c_rdata [N], d_rdata [N], m_addr [N], m_wdata [N], m_rdata [N];
   rsp_t pq [N][$];
   rsp_t mq [N][$];
   logic [31:0] lc [N], ld [N];
   int cyc = 0, waitc = 0, errors = 0, checks = 0;
   bit turn = 1'b0, ec = 1'b0, ed = 1'b0;
   logic s_cg, s_dg, s_mwe, s_crv, s_anyrv, s_busy;
   logic [31:0] s_crd, s_mwd;

   always #5 clk = ~clk;

   for (genvar k = 0; k < N; k++) begin : g
      dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2*k+1), .STARVE_MAX(SM)) u (
         .clk(clk), .reset(reset),
         .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
         .c_gnt(c_gnt[k]), .c_rvalid(c_rvalid[k]), .c_rdata(c_rdata[k]),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
         .d_gnt(d_gnt[k]), .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]),
         .m_en(m_en[k]), .m_we(m_we[k]), .m_addr(m_addr[k]), .m_wdata(m_wdata[k]),
         .m_rdata(m_rdata[k]), .busy(busy[k])
      );
   end

   function automatic logic [31:0] f(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s[%0d] cyc=%0d got=%h exp=%h", tag, k, cyc, got, exp);
      end
   endtask

   task automatic setc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dt);
      c_req = r; c_we = w; c_addr = a; c_wdata = dt;
   endtask

   task automatic setd(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dt);
      d_req = r; d_we = w; d_addr = a; d_wdata = dt;
   endtask

   task automatic cycle();
      bit rv, own, bz;
      for (int k = 0; k < N; k++) begin
         if (mq[k].size() != 0 && mq[k][0].due == cyc) m_rdata[k] = mq[k].pop_front().data;
         else m_rdata[k] = $urandom;
      end
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            pq[k].delete();
            lc[k] = '0;
            ld[k] = '0;
         end
         waitc = 0;
         turn = 1'b0;
      end
      ec = reset && c_req && (!turn || !d_req);
      ed = reset && d_req && (turn || !c_req);
      #3;
      s_anyrv = 1'b0;
      for (int k = 0; k < N; k++) begin
         bz = pq[k].size() != 0;
         rv = bz && pq[k][0].due == cyc;
         own = rv && pq[k][0].own;
         chk("c_gnt", k, 32'(c_gnt[k]), 32'(ec));
         chk("d_gnt", k, 32'(d_gnt[k]), 32'(ed));
         chk("m_en", k, 32'(m_en[k]), 32'(ec || ed));
         chk("m_we", k, 32'(m_we[k]), 32'(ec ? c_we : (ed && d_we)));
         if (ec || ed) begin
            chk("m_addr", k, m_addr[k], ec ? c_addr : d_addr);
            chk("m_wdata", k, m_wdata[k], ec ? c_wdata : d_wdata);
         end
         chk("c_rvalid", k, 32'(c_rvalid[k]), 32'(rv && !own));
         chk("d_rvalid", k, 32'(d_rvalid[k]), 32'(rv && own));
         if (rv) begin
            if (own) ld[k] = pq[k][0].data;
            else lc[k] = pq[k][0].data;
            void'(pq[k].pop_front());
         end
         chk("c_rdata", k, c_rdata[k], lc[k]);
         chk("d_rdata", k, d_rdata[k], ld[k]);
         chk("busy", k, 32'(busy[k]), 32'(bz));
         s_anyrv = s_anyrv | c_rvalid[k] | d_rvalid[k];
         if (m_en[k] && !m_we[k]) mq[k].push_back('{cyc + 2*k + 1, 1'b0, f(m_addr[k])});
         if ((ec && !c_we) || (ed && !d_we)) pq[k].push_back('{cyc + 2*k + 1, ed, f(ed ? d_addr : c_addr)});
      end
      s_cg = c_gnt[0]; s_dg = d_gnt[0]; s_mwe = m_we[0]; s_mwd = m_wdata[0];
      s_crv = c_rvalid[0]; s_crd = c_rdata[0]; s_busy = busy[1];
      if (reset) begin
         waitc = (ed || !d_req) ? 0 : ((waitc < 255) ? waitc + 1 : 255);
         turn = waitc >= SM;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      reset = 1'b0;
      setc(1'b1, 1'b0, 32'h44, 32'h1);
      setd(1'b1, 1'b1, 32'h8, 32'h2);
      for (int k = 0; k < N; k++) m_rdata[k] = '0;
      @(posedge clk);
      #1;
      cycle();
      cycle();
      reset = 1'b1;
      setc(1'b0, 1'b0, 32'h0, 32'h0);
      setd(1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
      setc(1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      chk("rd1_gnt", 0, 32'(s_cg), 32'd1);
      setc(1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
      chk("rd1_rvalid", 0, 32'(s_crv), 32'd1);
      chk("rd1_rdata", 0, s_crd, 32'hDEADBEEF);
      cycle();
      setc(1'b1, 1'b1, 32'h100, 32'hCAFE);
      setd(1'b1, 1'b0, 32'h200, 32'h0);
      for (int i = 0; i < 27; i++) begin
         cycle();
         chk("starve_pat", 0, 32'(s_dg), 32'(i % 9 == 8));
      end
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) begin
            setc(1'b1, 1'b0, 32'(i * 4), 32'h0);
            setd(1'b0, 1'b0, 32'h0, 32'h0);
         end else begin
            setc(1'b0, 1'b0, 32'h0, 32'h0);
            setd(1'b1, 1'b0, 32'(32'h300 + i * 4), 32'h0);
         end
         cycle();
         if (i > 0) chk("busy_alt", 1, 32'(s_busy), 32'd1);
      end
      setc(1'b0, 1'b0, 32'h0, 32'h0);
      setd(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) cycle();
      setd(1'b1, 1'b1, 32'h20, 32'h12345678);
      cycle();
      chk("dwr_gnt", 0, 32'(s_dg), 32'd1);
      chk("dwr_we", 0, 32'(s_mwe), 32'd1);
      chk("dwr_wdata", 0, s_mwd, 32'h12345678);
      setd(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) begin
         cycle();
         chk("dwr_norv", 0, 32'(s_anyrv), 32'd0);
      end
      setc(1'b1, 1'b0, 32'h40, 32'h0);
      cycle();
      setc(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rst_norv", 0, 32'(s_anyrv), 32'd0);
         chk("rst_busy", 1, 32'(s_busy), 32'd0);
      end
      setc(1'b1, 1'b1, 32'h80, 32'h5);
      setd(1'b1, 1'b0, 32'h90, 32'h0);
      repeat (5) cycle();
      setd(1'b0, 1'b0, 32'h90, 32'h0);
      cycle();
      setd(1'b1, 1'b0, 32'h90, 32'h0);
      for (int i = 0; i < 9; i++) begin
         cycle();
         chk("withdraw", 0, 32'(s_dg), 32'(i == 8));
      end
      setc(1'b0, 1'b0, 32'h0, 32'h0);
      setd(1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
      for (int n = 0; n < 3000; n++) begin
         reset = $urandom_range(0, 299) != 0;
         if (!c_req || ec) setc($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom);
         else if ($urandom_range(0, 19) == 0) c_req = 1'b0;
         if (!d_req || ed) setd($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom);
         else if ($urandom_range(0, 19) == 0) d_req = 1'b0;
         cycle();
      end
      reset = 1'b1;
      setc(1'b0, 1'b0, 32'h0, 32'h0);
      setd(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (5) cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
